// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter.
package mem_arb_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;
endpackage

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for one single-ported unified memory.
// Data wins in IDLE, bounded by a run counter so fetch cannot starve.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MAX_D_RUN = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_cancel,
   output logic              if_done,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_stall,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_done,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_stall,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int RUN_W = $clog2(MAX_D_RUN + 1);

   state_t            r_state;
   state_t            w_next;
   owner_t            r_owner;
   logic [RUN_W-1:0]  r_d_run;
   logic              r_cancel;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_if_rdata;
   logic [DATA_W-1:0] r_d_rdata;
   logic              w_grant_d;
   logic              w_grant_i;

   always_comb begin
      w_grant_d = d_req && (!if_req || (r_d_run < RUN_W'(MAX_D_RUN)));
      w_grant_i = !w_grant_d && if_req;
   end

   // A completion seen in ISSUE is illegal and deliberately ignored.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_grant_d || w_grant_i) w_next = ISSUE;
         ISSUE:   w_next = WAIT;
         WAIT:    if (mem_rvalid) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_owner    <= OWN_NONE;
         r_d_run    <= '0;
         r_cancel   <= 1'b0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_if_rdata <= '0;
         r_d_rdata  <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            IDLE: begin
               if (w_grant_d) begin
                  r_owner <= OWN_D;
                  r_we    <= d_we;
                  r_addr  <= d_addr;
                  r_wdata <= d_wdata;
                  if (!if_req)
                     r_d_run <= '0;
                  else if (r_d_run != RUN_W'(MAX_D_RUN))
                     r_d_run <= r_d_run + RUN_W'(1);
               end else if (w_grant_i) begin
                  r_owner <= OWN_I;
                  r_we    <= 1'b0;
                  r_addr  <= if_addr;
                  r_wdata <= '0;
                  r_d_run <= '0;
               end
            end
            ISSUE: begin
               if (if_cancel && r_owner == OWN_I) r_cancel <= 1'b1;
            end
            WAIT: begin
               if (if_cancel && r_owner == OWN_I) r_cancel <= 1'b1;
               if (mem_rvalid) begin
                  if (r_owner == OWN_I) r_if_rdata <= mem_rdata;
                  if (r_owner == OWN_D) r_d_rdata  <= mem_rdata;
               end
            end
            DONE: begin
               r_cancel <= 1'b0;
               r_owner  <= OWN_NONE;
            end
            default: r_owner <= OWN_NONE;
         endcase
      end
   end

   assign if_done   = (r_state == DONE) && (r_owner == OWN_I)
                      && !r_cancel && !if_cancel;
   assign d_done    = (r_state == DONE) && (r_owner == OWN_D);
   assign if_stall  = if_req & ~if_done;
   assign d_stall   = d_req & ~d_done;
   assign if_rdata  = r_if_rdata;
   assign d_rdata   = r_d_rdata;
   assign mem_en    = (r_state == ISSUE);
   assign mem_we    = r_we;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a variable-latency memory.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req, if_cancel, if_done, if_stall;
   logic [31:0] if_addr, if_rdata;
   logic        d_req, d_we, d_done, d_stall;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic        mem_en, mem_we, mem_rvalid, busy;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_RUN(4)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
      .if_done(if_done), .if_rdata(if_rdata), .if_stall(if_stall),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_done(d_done), .d_rdata(d_rdata), .d_stall(d_stall),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mexp_t;

   typedef struct {
      bit          is_d;
      bit          chk;
      logic [31:0] rd;
   } dexp_t;

   mexp_t mq[$];
   dexp_t dq[$];
   int    n_chk   = 0;
   int    n_pass  = 0;
   int    n_idone = 0;
   int    mem_lat = 2;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   function automatic logic [31:0] rom(input logic [31:0] a);
      case (a)
         32'h40:  return 32'h8C22_0004;
         32'h80:  return 32'h0085_1020;
         32'h20:  return 32'h1000_FFFF;
         default: return 32'hC0DE_0000 | {16'h0, a[15:0]};
      endcase
   endfunction

   // Memory: completes each access mem_lat cycles after mem_en.
   initial begin
      bit          pend = 0;
      int          cnt  = 0;
      logic [31:0] data = '0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      forever begin
         @(posedge clk); #1;
         mem_rvalid = 1'b0;
         if (pend) begin
            if (cnt == 1) begin
               mem_rvalid = 1'b1;
               mem_rdata  = data;
               pend       = 0;
            end else cnt--;
         end
         if (mem_en) begin
            pend = 1;
            cnt  = mem_lat;
            data = rom(mem_addr);
         end
      end
   end

   always @(negedge clk) begin
      mexp_t m;
      dexp_t e;
      if (!reset) begin
         if (mem_en) begin
            if (mq.size() == 0) chk("mem_en_unexpected", 32'(mem_en), 0);
            else begin
               m = mq.pop_front();
               chk("mem_we", 32'(mem_we), 32'(m.we));
               chk("mem_addr", mem_addr, m.addr);
               if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
            end
         end
         if (if_done) begin
            n_idone++;
            if (dq.size() == 0) chk("if_done_unexpected", 32'(if_done), 0);
            else begin
               e = dq.pop_front();
               chk("done_owner_i", 32'(e.is_d), 0);
               chk("if_rdata", if_rdata, e.rd);
            end
         end
         if (d_done) begin
            if (dq.size() == 0) chk("d_done_unexpected", 32'(d_done), 0);
            else begin
               e = dq.pop_front();
               chk("done_owner_d", 32'(e.is_d), 1);
               if (e.chk) chk("d_rdata", d_rdata, e.rd);
            end
         end
      end
   end

   task automatic push_i(input logic [31:0] a, input bit want_done);
      mq.push_back('{we: 1'b0, addr: a, wdata: 32'h0});
      if (want_done) dq.push_back('{is_d: 0, chk: 1, rd: rom(a)});
   endtask

   task automatic push_d(input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd);
      mq.push_back('{we: we, addr: a, wdata: wd});
      dq.push_back('{is_d: 1, chk: !we, rd: rd});
   endtask

   task automatic i_fetch(input logic [31:0] a, input bit drop);
      int k = 0;
      if_req  = 1'b1;
      if_addr = a;
      @(negedge clk);
      while (!if_done && k < 60) begin
         @(negedge clk);
         k++;
      end
      chk("if_done_seen", 32'(k < 60), 1);
      @(posedge clk); #1;
      if (drop) if_req = 1'b0;
   endtask

   task automatic d_access(input logic we, input logic [31:0] a,
                           input logic [31:0] wd, input bit drop);
      int k = 0;
      d_req   = 1'b1;
      d_we    = we;
      d_addr  = a;
      d_wdata = wd;
      @(negedge clk);
      while (!d_done && k < 60) begin
         @(negedge clk);
         k++;
      end
      chk("d_done_seen", 32'(k < 60), 1);
      @(posedge clk); #1;
      if (drop) d_req = 1'b0;
   endtask

   task automatic wait_idle();
      int k = 0;
      while ((busy || dq.size() != 0) && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("drain", 32'(k < 100), 1);
      chk("mq_empty", mq.size(), 0);
      @(posedge clk); #1;
   endtask

   // Lone fetch at lat 2: mem_en in cycle 1, done in cycle 4.
   task automatic timed_fetch(input logic [31:0] a);
      push_i(a, 1);
      @(posedge clk); #1;
      if_req  = 1'b1;
      if_addr = a;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk($sformatf("t_mem_en_c%0d", c), 32'(mem_en), 32'(c == 1));
         chk($sformatf("t_if_done_c%0d", c), 32'(if_done), 32'(c == 4));
         chk($sformatf("t_if_stall_c%0d", c), 32'(if_stall), 32'(c < 4));
      end
      @(posedge clk); #1;
      if_req = 1'b0;
   endtask

   logic        tv_we [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
   logic [31:0] tv_a  [5] = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110};
   logic [31:0] tv_wd [5] = '{32'h1111_1111, 32'h0, 32'h3333_3333,
                              32'h0, 32'h0};
   logic [31:0] tv_rd [5] = '{32'h0, 32'hC0DE_0104, 32'h0,
                              32'hC0DE_010C, 32'hC0DE_0110};

   initial begin
      int n0;
      reset     = 1'b1;
      if_req    = 1'b0;
      if_addr   = '0;
      if_cancel = 1'b0;
      d_req     = 1'b0;
      d_we      = 1'b0;
      d_addr    = '0;
      d_wdata   = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_mem_en", 32'(mem_en), 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_if_rdata", if_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      chk("rst_stalls", {30'h0, if_stall, d_stall}, 0);

      // 1: lone fetch with latency profile
      mem_lat = 2;
      timed_fetch(32'h40);
      wait_idle();

      // 2: lone store at minimum memory latency
      mem_lat = 1;
      push_d(1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0);
      n0 = n_idone;
      d_access(1'b1, 32'h10, 32'hDEAD_BEEF, 1);
      wait_idle();
      chk("store_no_if_done", n_idone - n0, 0);

      // 3: simultaneous requests, data first
      push_d(1'b0, 32'h14, 32'h0, 32'hC0DE_0014);
      push_i(32'h80, 1);
      fork
         d_access(1'b0, 32'h14, 32'h0, 1);
         i_fetch(32'h80, 1);
      join
      wait_idle();

      // 4: starvation guard, grant order D D D D I D
      mem_lat = 2;
      for (int i = 0; i < 4; i++) push_d(tv_we[i], tv_a[i], tv_wd[i], tv_rd[i]);
      push_i(32'h40, 1);
      push_d(tv_we[4], tv_a[4], tv_wd[4], tv_rd[4]);
      fork
         for (int i = 0; i < 5; i++) d_access(tv_we[i], tv_a[i], tv_wd[i], i == 4);
         i_fetch(32'h40, 1);
      join
      wait_idle();

      // 5: cancel in WAIT, then a normal fetch
      mem_lat = 3;
      push_i(32'h20, 0);
      n0 = n_idone;
      if_req  = 1'b1;
      if_addr = 32'h20;
      @(posedge clk); #1;
      @(posedge clk); #1;
      if_cancel = 1'b1;
      if_req    = 1'b0;
      @(posedge clk); #1;
      if_cancel = 1'b0;
      wait_idle();
      chk("cancel_no_if_done", n_idone - n0, 0);
      chk("cancel_busy", 32'(busy), 0);
      push_i(32'h80, 1);
      i_fetch(32'h80, 1);
      wait_idle();

      // 6: reset in WAIT, stray completion after it
      mem_lat = 2;
      push_i(32'h44, 0);
      n0 = n_idone;
      if_req  = 1'b1;
      if_addr = 32'h44;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset  = 1'b1;
      if_req = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rw_busy", 32'(busy), 0);
      chk("rw_mem_en", 32'(mem_en), 0);
      chk("rw_mem_addr", mem_addr, 0);
      chk("rw_if_rdata", if_rdata, 0);
      chk("rw_d_rdata", d_rdata, 0);
      chk("rw_dones", {30'h0, if_done, d_done}, 0);
      @(negedge clk);
      chk("rw_stray_busy", 32'(busy), 0);
      chk("rw_no_if_done", n_idone - n0, 0);
      timed_fetch(32'h40);
      wait_idle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: run did not finish, %0d/%0d so far", n_pass, n_chk);
      $fatal(1);
   end

endmodule
